// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32 control path: opcodes, ALU
// operations, FSM states and the datapath mux select codes.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_SLTU = 3'd5,
        ALU_XOR  = 3'd6
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC, S_LUI
    } state_t;

    // Coarse grouping of states as seen by the ALU decoder.
    typedef enum logic [2:0] {
        CLS_OTHER, CLS_DECODE, CLS_EXECR, CLS_EXECI, CLS_BRANCH
    } state_class_t;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_DATA   = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;
    localparam logic [1:0] RES_IMM    = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    // State-only control bits; branch PCWrite is added on top in the FSM.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_EXECI, S_JALR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            S_EXECR, S_BRANCH: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.result_src = RES_ALUOUT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_JAL, S_JALRPC: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_LUI: begin
                c.result_src = RES_IMM;
                c.reg_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_class_t class_of(input state_t s);
        case (s)
            S_DECODE: return CLS_DECODE;
            S_EXECR:  return CLS_EXECR;
            S_EXECI:  return CLS_EXECI;
            S_BRANCH: return CLS_BRANCH;
            default:  return CLS_OTHER;
        endcase
    endfunction

    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:     return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation and legality decode from the state class and IR fields.
module alu_decoder
    import multicycle_controller_pkg::*;
#(
    parameter int ALU_W = 3
) (
    input  state_class_t     cls,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic [6:0]       op,
    output logic [ALU_W-1:0] alu_control,
    output logic             illegal
);

    // Decode the ALU op for execute/branch states and flag bad encodings in DECODE.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        alu_control = ALU_W'(ALU_ADD);
        illegal     = 1'b0;
        case (cls)
            CLS_DECODE: begin
                case (op)
                    OP_R, OP_I: illegal = (funct3 == 3'b001) || (funct3 == 3'b101);
                    OP_BRANCH:  illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
                    OP_LW, OP_SW, OP_JAL, OP_JALR, OP_LUI: illegal = 1'b0;
                    default:    illegal = 1'b1;
                endcase
            end
            CLS_EXECR, CLS_EXECI: begin
                case (funct3)
                    3'b000:  alu_control = (cls == CLS_EXECR && funct7b5) ? ALU_W'(ALU_SUB)
                                                                          : ALU_W'(ALU_ADD);
                    3'b010:  alu_control = ALU_W'(ALU_SLT);
                    3'b011:  alu_control = ALU_W'(ALU_SLTU);
                    3'b100:  alu_control = ALU_W'(ALU_XOR);
                    3'b110:  alu_control = ALU_W'(ALU_OR);
                    3'b111:  alu_control = ALU_W'(ALU_AND);
                    default: alu_control = ALU_W'(ALU_ADD);
                endcase
            end
            CLS_BRANCH: begin
                case (funct3)
                    3'b100, 3'b101: alu_control = ALU_W'(ALU_SLT);
                    3'b110, 3'b111: alu_control = ALU_W'(ALU_SLTU);
                    default:        alu_control = ALU_W'(ALU_SUB);
                endcase
            end
            default: alu_control = ALU_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32 datapath. State-only controls are
// registered alongside the state; ALUControl, illegal and branch PCWrite are
// decoded from the current state and the stable IR fields.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int ALU_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ImmSrc,
    output logic [ALU_W-1:0] ALUControl,
    output logic             RegWrite,
    output logic             illegal
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl_q;
    logic   dec_illegal;
    logic   branch_taken;

    alu_decoder #(.ALU_W(ALU_W)) u_alu_decoder (
        .cls        (class_of(state)),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op         (op),
        .alu_control(ALUControl),
        .illegal    (dec_illegal)
    );

    // Next-state selection from the current state and opcode.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                if (dec_illegal) begin
                    next_state = S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: next_state = S_MEMADR;
                        OP_R:         next_state = S_EXECR;
                        OP_I:         next_state = S_EXECI;
                        OP_BRANCH:    next_state = S_BRANCH;
                        OP_JAL:       next_state = S_JAL;
                        OP_JALR:      next_state = S_JALR;
                        OP_LUI:       next_state = S_LUI;
                        default:      next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: next_state = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL, S_JALRPC: next_state = S_ALUWB;
            S_JALR:    next_state = S_JALRPC;
            default:   next_state = S_FETCH;
        endcase
    end

    // State register plus the control bits belonging to the state being entered.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep state and ctrl_q updating together at the edge.
        if (rst) begin
            state  <= S_FETCH;
            ctrl_q <= ctrl_for(S_FETCH);
        end else begin
            state  <= next_state;
            ctrl_q <= ctrl_for(next_state);
        end
    end

    // beq/bge/bgeu take on zero; bne/blt/bltu take on ~zero.
    assign branch_taken = zero ^ funct3[0] ^ funct3[2];

    assign PCWrite   = ctrl_q.pc_write | ((state == S_BRANCH) & branch_taken);
    assign AdrSrc    = ctrl_q.adr_src;
    assign MemWrite  = ctrl_q.mem_write;
    assign IRWrite   = ctrl_q.ir_write;
    assign ResultSrc = ctrl_q.result_src;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign RegWrite  = ctrl_q.reg_write;
    assign ImmSrc    = imm_src_for(op);
    assign illegal   = dec_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction reference
// model pushes the expected per-cycle outputs; a negedge monitor compares.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;

    multicycle_controller #(.ALU_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .zero      (zero),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .ALUControl(ALUControl),
        .RegWrite  (RegWrite),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] rsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] imm;
        logic [2:0] aluc;
        logic       regw;
        logic       ill;
    } rec_t;

    rec_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;
    rec_t  got;

    assign got = '{PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ImmSrc, ALUControl, RegWrite, illegal};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, actual, expected);
        end
    endtask

    // Monitor: one expected record per clock cycle, compared mid-cycle.
    always @(negedge clk) begin
        rec_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, 32'(got), 32'(e));
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b1100111, 7'b0010011: return 3'd0;
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b1101111: return 3'd3;
            7'b0110111: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic rec_t mk(input logic [6:0] o, input logic pcw, adr, memw, irw,
                                input logic [1:0] rsrc, srca, srcb,
                                input logic [2:0] aluc, input logic regw, ill);
        return '{pcw, adr, memw, irw, rsrc, srca, srcb, exp_imm(o), aluc, regw, ill};
    endfunction

    function automatic bit is_legal(input logic [6:0] o, input logic [2:0] f3);
        case (o)
            7'b0110011, 7'b0010011: return !(f3 == 3'd1 || f3 == 3'd5);
            7'b1100011:             return !(f3 == 3'd2 || f3 == 3'd3);
            7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b0110111: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] arith_op(input logic [2:0] f3, input bit rtype, input logic b5);
        case (f3)
            3'd0:    return (rtype && b5) ? 3'd1 : 3'd0;
            3'd2:    return 3'd4;
            3'd3:    return 3'd5;
            3'd4:    return 3'd6;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    task automatic push(input string n, input rec_t r);
        exp_q.push_back(r);
        name_q.push_back(n);
    endtask

    // Builds the full expected cycle list for one instruction; returns its length.
    task automatic model(input logic [6:0] o, input logic [2:0] f3, input logic b5,
                         input logic z, input string tag, output int cycles);
        logic [2:0] bop;
        logic       taken;
        push({tag, ".fetch"}, mk(o, 1, 0, 0, 1, 2'd2, 2'd0, 2'd2, 3'd0, 0, 0));
        if (!is_legal(o, f3)) begin
            push({tag, ".decode_illegal"}, mk(o, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0, 1));
            cycles = 2;
            return;
        end
        push({tag, ".decode"}, mk(o, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0, 0));
        case (o)
            7'b0000011: begin
                push({tag, ".memadr"},  mk(o, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0, 0));
                push({tag, ".memread"}, mk(o, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0));
                push({tag, ".memwb"},   mk(o, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, 1, 0));
                cycles = 5;
            end
            7'b0100011: begin
                push({tag, ".memadr"},   mk(o, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0, 0));
                push({tag, ".memwrite"}, mk(o, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0));
                cycles = 4;
            end
            7'b0110011, 7'b0010011: begin
                if (o == 7'b0110011)
                    push({tag, ".execr"}, mk(o, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, arith_op(f3, 1, b5), 0, 0));
                else
                    push({tag, ".execi"}, mk(o, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, arith_op(f3, 0, b5), 0, 0));
                push({tag, ".aluwb"}, mk(o, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 1, 0));
                cycles = 4;
            end
            7'b1100011: begin
                case (f3)
                    3'd0:    begin bop = 3'd1; taken = z;  end
                    3'd1:    begin bop = 3'd1; taken = !z; end
                    3'd4:    begin bop = 3'd4; taken = !z; end
                    3'd5:    begin bop = 3'd4; taken = z;  end
                    3'd6:    begin bop = 3'd5; taken = !z; end
                    default: begin bop = 3'd5; taken = z;  end
                endcase
                push({tag, ".branch"}, mk(o, taken, 0, 0, 0, 2'd0, 2'd2, 2'd0, bop, 0, 0));
                cycles = 3;
            end
            7'b1101111: begin
                push({tag, ".jal"},   mk(o, 1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 0, 0));
                push({tag, ".aluwb"}, mk(o, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 1, 0));
                cycles = 4;
            end
            7'b1100111: begin
                push({tag, ".jalr"},   mk(o, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0, 0));
                push({tag, ".jalrpc"}, mk(o, 1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 0, 0));
                push({tag, ".aluwb"},  mk(o, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 1, 0));
                cycles = 5;
            end
            default: begin
                push({tag, ".lui"}, mk(o, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 3'd0, 1, 0));
                cycles = 3;
            end
        endcase
    endtask

    // Called #1 after an edge that left the DUT in FETCH.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic b5,
                             input logic z, input string tag);
        int n;
        op = o; funct3 = f3; funct7b5 = b5; zero = z;
        model(o, f3, b5, z, tag, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [6:0] op_list [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0000000};

    initial begin
        rst = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        push("reset_state", mk(7'b0, 1, 0, 0, 1, 2'd2, 2'd0, 2'd2, 3'd0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, "add");
        run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, "sub");
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, "lw");
        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, "sw");
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, "beq_z1");
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, "beq_z0");
        run_instr(7'b1100011, 3'd4, 1'b0, 1'b0, "blt_z0");
        run_instr(7'b1100011, 3'd7, 1'b0, 1'b1, "bgeu_z1");
        run_instr(7'b1100111, 3'd0, 1'b0, 1'b0, "jalr");
        run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, "jal");
        run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, "lui");
        run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, "op0");
        run_instr(7'b0010011, 3'd1, 1'b0, 1'b0, "slli");
        run_instr(7'b1100011, 3'd2, 1'b0, 1'b0, "br_f3_2");

        // Reset while in MEMREAD: the lw must not retire.
        op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
        push("rstlw.fetch",   mk(op, 1, 0, 0, 1, 2'd2, 2'd0, 2'd2, 3'd0, 0, 0));
        push("rstlw.decode",  mk(op, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0, 0));
        push("rstlw.memadr",  mk(op, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0, 0));
        push("rstlw.memread", mk(op, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0));
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, "after_rst_addi");

        for (int i = 0; i < 200; i++) begin
            int         k;
            logic [6:0] o;
            k = $urandom_range(0, 9);
            o = (k == 9) ? 7'($urandom) : op_list[k];
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
